coef_bank: RTL and testbench

- Consumer end of the twiddle-coefficient mapper stream. The mapper emits c, c+s and c-s coefficient words with an address, a write enable and a done pulse.
- This block issues the per-stage load request (start/stage) to the mapper and captures the returned stream into a local N/2-entry coefficient store.
- It then serves single-cycle-latency reads to the butterfly datapath.
- It sits between the coefficient mapper and the FFT butterfly in each FFT stage.

---
 rtl/coef_bank.sv | 183 ++++++++++++++++++
 tb/tb_coef_bank.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/coef_bank.sv
// rtl/coef_bank.sv - per-stage twiddle coefficient store loaded from the mapper stream, single-cycle read port
// Optional double buffering when COEF_BANK_PINGPONG_EN is defined.
module coef_bank #(
    parameter int N   = 16,
    parameter int MSB = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_req,
    input  logic [$clog2(N/4)-1:0] load_stage,
    output logic                   map_start,
    output logic [$clog2(N/4)-1:0] map_stage,
    input  logic                   wr_we,
    input  logic [$clog2(N/2)-1:0] wr_addr,
    input  logic [MSB-1:0]         wr_c,
    input  logic [MSB-1:0]         wr_cps,
    input  logic [MSB-1:0]         wr_cms,
    input  logic                   wr_dv,
    output logic                   bank_ready,
    output logic                   load_err,
    input  logic                   rd_en,
    input  logic [$clog2(N/2)-1:0] rd_addr,
    output logic                   rd_valid,
    output logic [MSB-1:0]         rd_c,
    output logic [MSB-1:0]         rd_cps,
    output logic [MSB-1:0]         rd_cms,
    output logic                   rd_miss
);
    localparam int AW    = $clog2(N/2);
    localparam int SW    = $clog2(N/4);
    localparam int DEPTH = N/2;
    localparam int WW    = 3*MSB;
`ifdef COEF_BANK_PINGPONG_EN
    localparam int IW    = AW + 1;
`else
    localparam int IW    = AW;
`endif
    localparam logic [DEPTH-1:0] BIT0 = DEPTH'(1);

    typedef enum logic [1:0] {IDLE, REQ, LOAD, FULL} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_commit;
    logic              w_fail;
    logic              w_enter_req;
    logic              w_wr_fire;
    logic              w_full;
    logic [DEPTH-1:0]  w_set;
    logic [IW-1:0]     w_wr_idx;
    logic [IW-1:0]     w_rd_idx;
    logic [WW-1:0]     w_rd_word;

    logic [SW-1:0]     r_map_stage;
    logic [DEPTH-1:0]  r_bitmap;
    logic [AW-1:0]     r_addr_q;
    logic              r_we_q;
    logic              r_dv_q;
    logic              r_bank_ready;
    logic              r_load_err;
    logic              r_rd_valid;
    logic              r_rd_miss;
    logic [MSB-1:0]    r_rd_c;
    logic [MSB-1:0]    r_rd_cps;
    logic [MSB-1:0]    r_rd_cms;
    logic [WW-1:0]     r_mem [0:(1<<IW)-1];
`ifdef COEF_BANK_PINGPONG_EN
    logic              r_active;

    assign w_wr_idx = {~r_active, r_addr_q};
    assign w_rd_idx = {r_active, rd_addr};
`else
    assign w_wr_idx = r_addr_q;
    assign w_rd_idx = rd_addr;
`endif

    // Data lags its address by one beat, so the write fires from the registered address.
    assign w_wr_fire   = r_we_q && (r_state == LOAD);
    assign w_set       = w_wr_fire ? (BIT0 << r_addr_q) : '0;
    assign w_full      = &(r_bitmap | w_set);
    assign w_enter_req = (w_state_nxt == REQ);
    assign w_rd_word   = r_mem[w_rd_idx];

    always_comb begin
        w_state_nxt = r_state;
        w_commit    = 1'b0;
        w_fail      = 1'b0;
        unique case (r_state)
            IDLE: if (load_req) w_state_nxt = REQ;
            REQ:  w_state_nxt = LOAD;
            LOAD: begin
                if (load_req) begin
                    w_state_nxt = REQ;
                end else if (r_dv_q) begin
                    if (w_full) begin
                        w_state_nxt = FULL;
                        w_commit    = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                        w_fail      = 1'b1;
                    end
                end
            end
            FULL: if (load_req) w_state_nxt = REQ;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_map_stage  <= '0;
            r_bitmap     <= '0;
            r_addr_q     <= '0;
            r_we_q       <= 1'b0;
            r_dv_q       <= 1'b0;
            r_bank_ready <= 1'b0;
            r_load_err   <= 1'b0;
            r_rd_valid   <= 1'b0;
            r_rd_miss    <= 1'b0;
            r_rd_c       <= '0;
            r_rd_cps     <= '0;
            r_rd_cms     <= '0;
`ifdef COEF_BANK_PINGPONG_EN
            r_active     <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;

            if (w_enter_req) begin
                r_map_stage <= load_stage;
                r_load_err  <= 1'b0;
            end else if (w_fail) begin
                r_load_err  <= 1'b1;
            end

            if (wr_we) r_addr_q <= wr_addr;
            r_we_q <= wr_we && (r_state == LOAD);
            r_dv_q <= wr_dv && (r_state == LOAD);

            if (r_state == REQ)
                r_bitmap <= '0;
            else
                r_bitmap <= r_bitmap | w_set;

`ifdef COEF_BANK_PINGPONG_EN
            // Once the first bank is valid, readers keep it while the shadow reloads.
            if (w_commit) begin
                r_bank_ready <= 1'b1;
                r_active     <= ~r_active;
            end
`else
            if (w_commit)
                r_bank_ready <= 1'b1;
            else if (w_enter_req)
                r_bank_ready <= 1'b0;
`endif

            r_rd_valid <= rd_en && r_bank_ready;
            r_rd_miss  <= rd_en && !r_bank_ready;
            if (rd_en && r_bank_ready) begin
                r_rd_c   <= w_rd_word[WW-1 -: MSB];
                r_rd_cps <= w_rd_word[2*MSB-1 -: MSB];
                r_rd_cms <= w_rd_word[MSB-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_fire) r_mem[w_wr_idx] <= {wr_c, wr_cps, wr_cms};
    end

    assign map_start  = (r_state == REQ);
    assign map_stage  = r_map_stage;
    assign bank_ready = r_bank_ready;
    assign load_err   = r_load_err;
    assign rd_valid   = r_rd_valid;
    assign rd_miss    = r_rd_miss;
    assign rd_c       = r_rd_c;
    assign rd_cps     = r_rd_cps;
    assign rd_cms     = r_rd_cms;

endmodule

// File: tb/tb_coef_bank.sv
// tb/tb_coef_bank.sv - directed bench for coef_bank (N=16, MSB=16); COEF_BANK_PINGPONG_EN adds the double-buffer scenario
module tb_coef_bank;
`ifdef COEF_BANK_PINGPONG_EN
    localparam bit PP = 1'b1;
`else
    localparam bit PP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_req = 1'b0;
    logic [1:0]  load_stage = 2'd0;
    logic        map_start;
    logic [1:0]  map_stage;
    logic        wr_we = 1'b0;
    logic [2:0]  wr_addr = 3'd0;
    logic [15:0] wr_c = 16'h0, wr_cps = 16'h0, wr_cms = 16'h0;
    logic        wr_dv = 1'b0;
    logic        bank_ready, load_err;
    logic        rd_en = 1'b0;
    logic [2:0]  rd_addr = 3'd0;
    logic        rd_valid, rd_miss;
    logic [15:0] rd_c, rd_cps, rd_cms;

    int n_cmp = 0;
    int n_bad = 0;
    bit saw_miss, saw_nr, saw_bad;

    coef_bank #(.N(16), .MSB(16)) dut (
        .clk(clk), .rst(rst), .load_req(load_req), .load_stage(load_stage),
        .map_start(map_start), .map_stage(map_stage),
        .wr_we(wr_we), .wr_addr(wr_addr), .wr_c(wr_c), .wr_cps(wr_cps), .wr_cms(wr_cms), .wr_dv(wr_dv),
        .bank_ready(bank_ready), .load_err(load_err),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid),
        .rd_c(rd_c), .rd_cps(rd_cps), .rd_cms(rd_cms), .rd_miss(rd_miss)
    );

    always #5 clk = ~clk;

    // Kind 0 is the 127-scaled twiddle table (c=cos, s=sin of k*pi/8); other kinds are tagged patterns.
    function automatic logic [15:0] c_of(input int kind, input int a);
        if (kind != 0) return {4'(kind), 12'(a)};
        case (a)
            0: return 16'h007f; 1: return 16'h0075; 2: return 16'h005a; 3: return 16'h0031;
            4: return 16'h0000; 5: return 16'hffcf; 6: return 16'hffa6; default: return 16'hff8b;
        endcase
    endfunction

    function automatic logic [15:0] cps_of(input int kind, input int a);
        if (kind != 0) return {4'(kind), 4'h1, 8'(a)};
        case (a)
            0: return 16'h007f; 1: return 16'h00a6; 2: return 16'h00b4; 3: return 16'h00a6;
            4: return 16'h007f; 5: return 16'h0044; 6: return 16'h0000; default: return 16'hffbc;
        endcase
    endfunction

    function automatic logic [15:0] cms_of(input int kind, input int a);
        if (kind != 0) return {4'(kind), 4'h2, 8'(a)};
        case (a)
            0: return 16'h007f; 1: return 16'h0044; 2: return 16'h0000; 3: return 16'hffbc;
            4: return 16'hff81; 5: return 16'hff5a; 6: return 16'hff4c; default: return 16'hff5a;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_start(input logic [1:0] stage);
        load_req = 1'b1; load_stage = stage;
        step();
        load_req = 1'b0;
        step();
    endtask

    task automatic rd_monitor(input int kind, input int a);
        if (rd_miss) saw_miss = 1'b1;
        if (!bank_ready) saw_nr = 1'b1;
        if (!rd_valid || rd_c !== c_of(kind, a)) saw_bad = 1'b1;
    endtask

    // Mapper model: address at beat i, its data at beat i+1, done pulse after the last data beat.
    task automatic mapper_stream(input int kind, input int skip, input bit dup, input int rd_kind);
        int q[$];
        int ra;
        ra = 0;
        for (int a = 0; a < 8; a++) if (a != skip) q.push_back(a);
        if (dup) q.push_back(7);
        for (int i = 0; i <= q.size(); i++) begin
            wr_we = (i < q.size());
            if (i < q.size()) wr_addr = 3'(q[i]);
            if (i > 0) begin
                wr_c = c_of(kind, q[i-1]); wr_cps = cps_of(kind, q[i-1]); wr_cms = cms_of(kind, q[i-1]);
            end
            ra = i % 8;
            if (rd_kind >= 0) begin rd_en = 1'b1; rd_addr = 3'(ra); end
            step();
            if (rd_kind >= 0) rd_monitor(rd_kind, ra);
        end
        wr_we = 1'b0; wr_dv = 1'b1;
        step();
        if (rd_kind >= 0) rd_monitor(rd_kind, ra);
        wr_dv = 1'b0;
    endtask

    task automatic test_reset();
        step(); step();
        n_cmp++; if (bank_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready: got %0b want 0", bank_ready); end
        n_cmp++; if (map_start !== 1'b0 || map_stage !== 2'd0) begin n_bad++; $display("FAIL rst_map: got %0b/%0d want 0/0", map_start, map_stage); end
        n_cmp++; if ({load_err, rd_valid, rd_miss} !== 3'b000) begin n_bad++; $display("FAIL rst_flags: got %b want 000", {load_err, rd_valid, rd_miss}); end
        n_cmp++; if ({rd_c, rd_cps, rd_cms} !== 48'h0) begin n_bad++; $display("FAIL rst_data: got %h want 0", {rd_c, rd_cps, rd_cms}); end
        rst = 1'b0;
        load_start(2'd1);
        for (int a = 0; a < 3; a++) begin
            wr_we = 1'b1; wr_addr = 3'(a); wr_c = c_of(0, a);
            step();
        end
        wr_we = 1'b0;
        rst = 1'b1;
        #1;
        n_cmp++; if (bank_ready !== 1'b0 || map_start !== 1'b0 || load_err !== 1'b0) begin n_bad++; $display("FAIL midload_rst: got ready=%0b start=%0b err=%0b want 0/0/0", bank_ready, map_start, load_err); end
        n_cmp++; if (map_stage !== 2'd0) begin n_bad++; $display("FAIL midload_rst_stage: got %0d want 0", map_stage); end
        step();
        rst = 1'b0;
        rd_en = 1'b1; rd_addr = 3'd1;
        step();
        rd_en = 1'b0;
        n_cmp++; if (rd_miss !== 1'b1 || rd_valid !== 1'b0) begin n_bad++; $display("FAIL rst_miss: got miss=%0b valid=%0b want 1/0", rd_miss, rd_valid); end
        step();
        n_cmp++; if (rd_miss !== 1'b0) begin n_bad++; $display("FAIL miss_pulse: got %0b want 0", rd_miss); end
    endtask

    task automatic test_load();
        load_req = 1'b1; load_stage = 2'd1;
        step();
        load_req = 1'b0;
        n_cmp++; if (map_start !== 1'b1 || map_stage !== 2'd1) begin n_bad++; $display("FAIL req_pulse: got start=%0b stage=%0d want 1/1", map_start, map_stage); end
        step();
        n_cmp++; if (map_start !== 1'b0 || map_stage !== 2'd1) begin n_bad++; $display("FAIL req_end: got start=%0b stage=%0d want 0/1", map_start, map_stage); end
        mapper_stream(0, -1, 1'b1, -1);
        n_cmp++; if (bank_ready !== 1'b0) begin n_bad++; $display("FAIL ready_early: got %0b want 0", bank_ready); end
        rd_en = 1'b1; rd_addr = 3'd1;
        step();
        rd_en = 1'b0;
        n_cmp++; if (bank_ready !== 1'b1 || load_err !== 1'b0) begin n_bad++; $display("FAIL load_done: got ready=%0b err=%0b want 1/0", bank_ready, load_err); end
        n_cmp++; if (rd_miss !== 1'b1 || rd_valid !== 1'b0) begin n_bad++; $display("FAIL full_edge_miss: got miss=%0b valid=%0b want 1/0", rd_miss, rd_valid); end
        rd_en = 1'b1; rd_addr = 3'd1;
        step();
        rd_en = 1'b0;
        n_cmp++; if (rd_valid !== 1'b1 || rd_c !== 16'h0075) begin n_bad++; $display("FAIL rd_addr1: got valid=%0b c=%h want 1/0075", rd_valid, rd_c); end
        step();
        n_cmp++; if (rd_valid !== 1'b0 || rd_c !== 16'h0075) begin n_bad++; $display("FAIL rd_hold: got valid=%0b c=%h want 0/0075", rd_valid, rd_c); end
    endtask

    task automatic test_back_to_back();
        int addrs[3] = '{0, 7, 3};
        rd_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rd_addr = 3'(addrs[i]);
            step();
            n_cmp++;
            if (rd_valid !== 1'b1 || {rd_c, rd_cps, rd_cms} !== {c_of(0, addrs[i]), cps_of(0, addrs[i]), cms_of(0, addrs[i])}) begin
                n_bad++; $display("FAIL b2b_addr%0d: got valid=%0b %h/%h/%h want 1/%h/%h/%h", addrs[i], rd_valid, rd_c, rd_cps, rd_cms,
                                  c_of(0, addrs[i]), cps_of(0, addrs[i]), cms_of(0, addrs[i]));
            end
        end
        rd_en = 1'b0;
        step();
        n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_end: got %0b want 0", rd_valid); end
    endtask

    task automatic test_load_err();
        load_start(2'd2);
        mapper_stream(2, 5, 1'b0, -1);
        step();
        n_cmp++; if (load_err !== 1'b1 || bank_ready !== PP || map_start !== 1'b0) begin n_bad++; $display("FAIL skip_err: got err=%0b ready=%0b start=%0b want 1/%0b/0", load_err, bank_ready, map_start, PP); end
        rd_en = 1'b1; rd_addr = 3'd1;
        step();
        rd_en = 1'b0;
        n_cmp++; if (rd_miss !== !PP || rd_valid !== PP) begin n_bad++; $display("FAIL err_read: got miss=%0b valid=%0b want %0b/%0b", rd_miss, rd_valid, !PP, PP); end
        n_cmp++; if (rd_c !== (PP ? 16'h0075 : 16'h0031)) begin n_bad++; $display("FAIL err_read_data: got %h want %h", rd_c, PP ? 16'h0075 : 16'h0031); end
        load_req = 1'b1; load_stage = 2'd2;
        step();
        load_req = 1'b0;
        n_cmp++; if (load_err !== 1'b0 || map_start !== 1'b1) begin n_bad++; $display("FAIL err_clear_req: got err=%0b start=%0b want 0/1", load_err, map_start); end
        step();
        mapper_stream(2, -1, 1'b0, -1);
        step();
        n_cmp++; if (bank_ready !== 1'b1 || load_err !== 1'b0) begin n_bad++; $display("FAIL recover: got ready=%0b err=%0b want 1/0", bank_ready, load_err); end
        rd_en = 1'b1; rd_addr = 3'd5;
        step();
        rd_en = 1'b0;
        n_cmp++; if (rd_valid !== 1'b1 || rd_c !== c_of(2, 5)) begin n_bad++; $display("FAIL recover_rd5: got valid=%0b c=%h want 1/%h", rd_valid, rd_c, c_of(2, 5)); end
    endtask

    task automatic test_abort();
        load_start(2'd2);
        for (int a = 0; a < 4; a++) begin
            wr_we = 1'b1; wr_addr = 3'(a);
            wr_c = 16'hdead; wr_cps = 16'hdead; wr_cms = 16'hdead;
            step();
        end
        wr_we = 1'b0;
        load_req = 1'b1; load_stage = 2'd3;
        step();
        load_req = 1'b0;
        n_cmp++; if (map_start !== 1'b1 || map_stage !== 2'd3 || load_err !== 1'b0) begin n_bad++; $display("FAIL abort_req: got start=%0b stage=%0d err=%0b want 1/3/0", map_start, map_stage, load_err); end
        step();
        mapper_stream(3, -1, 1'b0, -1);
        step();
        n_cmp++; if (bank_ready !== 1'b1 || load_err !== 1'b0) begin n_bad++; $display("FAIL abort_done: got ready=%0b err=%0b want 1/0", bank_ready, load_err); end
        rd_en = 1'b1;
        for (int a = 0; a < 3; a += 2) begin
            rd_addr = 3'(a);
            step();
            n_cmp++;
            if (rd_valid !== 1'b1 || {rd_c, rd_cps, rd_cms} !== {c_of(3, a), cps_of(3, a), cms_of(3, a)}) begin
                n_bad++; $display("FAIL abort_rd%0d: got valid=%0b %h/%h/%h want 1/%h/%h/%h", a, rd_valid, rd_c, rd_cps, rd_cms, c_of(3, a), cps_of(3, a), cms_of(3, a));
            end
        end
        rd_en = 1'b0;
        step();
    endtask

`ifdef COEF_BANK_PINGPONG_EN
    task automatic test_pingpong();
        saw_miss = 1'b0; saw_nr = 1'b0; saw_bad = 1'b0;
        rd_en = 1'b1; rd_addr = 3'd6;
        load_req = 1'b1; load_stage = 2'd1;
        step();
        rd_monitor(3, 6);
        load_req = 1'b0;
        step();
        rd_monitor(3, 6);
        mapper_stream(1, -1, 1'b0, 3);
        rd_addr = 3'd1;
        step();
        n_cmp++; if (rd_valid !== 1'b1 || rd_c !== c_of(3, 1)) begin n_bad++; $display("FAIL pp_swap_edge: got valid=%0b c=%h want 1/%h", rd_valid, rd_c, c_of(3, 1)); end
        step();
        rd_en = 1'b0;
        n_cmp++; if (rd_valid !== 1'b1 || rd_c !== c_of(1, 1) || rd_cms !== cms_of(1, 1)) begin n_bad++; $display("FAIL pp_after_swap: got valid=%0b c=%h cms=%h want 1/%h/%h", rd_valid, rd_c, rd_cms, c_of(1, 1), cms_of(1, 1)); end
        n_cmp++; if ({saw_miss, saw_nr, saw_bad} !== 3'b000) begin n_bad++; $display("FAIL pp_during_load: got miss/notready/baddata=%b want 000", {saw_miss, saw_nr, saw_bad}); end
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_load();
        test_back_to_back();
        test_load_err();
        test_abort();
`ifdef COEF_BANK_PINGPONG_EN
        test_pingpong();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
